// File: rtl/lcd_pll_supervisor_if.sv
// Bundle between the LCD PLL supervisor and the PLL / LCD-domain consumers.
// master: the supervisor (samples pll_lock, drives the control/status outputs).
// slave : the PLL and LCD side (drives pll_lock, observes everything else).
interface lcd_pll_supervisor_if;
  logic       pll_lock;   // PLL lock output, asynchronous to clk
  logic       pll_reset;  // PLL reset request, active high
  logic       lcd_rst_n;  // LCD-domain reset, active low
  logic       ready;      // PLL locked and LCD domain released
  logic       fault;      // sticky, retries exhausted
  logic [1:0] retry_cnt;  // lock timeouts since last successful lock
  logic       lock_lost;  // one-cycle pulse on lock drop while running

  modport master (
    input  pll_lock,
    output pll_reset, lcd_rst_n, ready, fault, retry_cnt, lock_lost
  );

  modport slave (
    output pll_lock,
    input  pll_reset, lcd_rst_n, ready, fault, retry_cnt, lock_lost
  );
endinterface

// File: rtl/lcd_pll_supervisor.sv
// Sequencer and health monitor for the LCD pixel-clock PLL: pulses the PLL
// reset, waits for a stable synchronized lock, then releases the LCD domain.
// Ports: clk (25 MHz reference), rst_n (sync, active low), sup (master modport:
// pll_lock in; pll_reset, lcd_rst_n, ready, fault, retry_cnt, lock_lost out).
// Build option LCD_PLL_WATCHDOG_EN adds the WAIT timeout, retry count and FAULT.
// All outputs are registered and decoded from the next state.
module lcd_pll_supervisor #(
  parameter int STABLE_CYCLES = 1024,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int MAX_RETRY     = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lcd_pll_supervisor_if.master        sup
);

  if (STABLE_CYCLES < 1 || RESET_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
      MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_params
    $error("lcd_pll_supervisor: illegal parameter value");
  end

  localparam int RST_W = (RESET_CYCLES  > 1) ? $clog2(RESET_CYCLES)  : 1;
  localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             lock_meta_q, lock_s_q;
  logic [RST_W-1:0] rst_cnt_q;
  logic [STB_W-1:0] stb_cnt_q;
  logic             pll_reset_q, run_q, lock_lost_q;

`ifdef LCD_PLL_WATCHDOG_EN
  localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic [1:0]       retry_q, retry_d;
  logic             fault_q;
`endif

  // Next-state decode; only the synchronized lock is ever looked at.
  always_comb begin
    state_d = state_q;
`ifdef LCD_PLL_WATCHDOG_EN
    retry_d = retry_q;
`endif
    case (state_q)
      S_PLLRST: if (rst_cnt_q == RST_LAST) state_d = S_WAIT;
      S_WAIT: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s_q) begin
          state_d = S_STABLE;
        end
`ifdef LCD_PLL_WATCHDOG_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_PLLRST;
            retry_d = retry_q + 2'd1;
          end
        end
`endif
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d = S_RUN;
`ifdef LCD_PLL_WATCHDOG_EN
          retry_d = 2'd0;
`endif
        end
      end
      // A lock drop in RUN re-sequences without counting as a retry.
      S_RUN: if (!lock_s_q) state_d = S_PLLRST;
`ifdef LCD_PLL_WATCHDOG_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_PLLRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_PLLRST;
      rst_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      pll_reset_q <= 1'b1;
      run_q       <= 1'b0;
      lock_lost_q <= 1'b0;
`ifdef LCD_PLL_WATCHDOG_EN
      tmo_cnt_q   <= '0;
      retry_q     <= 2'd0;
      fault_q     <= 1'b0;
`endif
    end else begin
      lock_meta_q <= sup.pll_lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      // Counters run only while staying in their state and are zero on
      // entry, so they never reach past their terminal value.
      rst_cnt_q   <= (state_q == S_PLLRST && state_d == S_PLLRST) ? rst_cnt_q + 1'b1 : '0;
      stb_cnt_q   <= (state_q == S_STABLE && state_d == S_STABLE) ? stb_cnt_q + 1'b1 : '0;
      pll_reset_q <= (state_d == S_PLLRST) || (state_d == S_FAULT);
      run_q       <= (state_d == S_RUN);
      lock_lost_q <= (state_q == S_RUN) && (state_d == S_PLLRST);
`ifdef LCD_PLL_WATCHDOG_EN
      tmo_cnt_q   <= (state_q == S_WAIT && state_d == S_WAIT) ? tmo_cnt_q + 1'b1 : '0;
      retry_q     <= retry_d;
      fault_q     <= (state_d == S_FAULT);
`endif
    end
  end

  assign sup.pll_reset = pll_reset_q;
  assign sup.lcd_rst_n = run_q;
  assign sup.ready     = run_q;
  assign sup.lock_lost = lock_lost_q;
`ifdef LCD_PLL_WATCHDOG_EN
  assign sup.fault     = fault_q;
  assign sup.retry_cnt = retry_q;
`else
  assign sup.fault     = 1'b0;
  assign sup.retry_cnt = 2'd0;
`endif

endmodule

// File: doc/lcd_pll_supervisor.md
# lcd_pll_supervisor

Sequencer and health monitor for the LCD pixel-clock rPLL; it drives the PLL reset and watches its lock output. Runs on the same 25 MHz reference clock that feeds the PLL input. Holds the LCD-domain reset asserted until lock has been stable for a programmable time. Re-sequences the PLL on lock loss and, optionally, on lock timeout, escalating to a sticky fault after repeated failures.

## Interface
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1)
- RESET_CYCLES, 16: pll_reset pulse length in clk cycles (≥1)
- LOCK_TIMEOUT, 65536: cycles to wait for lock before a retry (watchdog build only)
- MAX_RETRY, 3: timeouts tolerated before fault (≤3)
- clk  in  1  25 MHz reference clock, same source as the PLL input
- rst_n  in  1  synchronous, active-low reset
- pll_lock  in  1  PLL lock output, asynchronous to clk
- pll_reset  out  1  PLL reset request, active high
- lcd_rst_n  out  1  LCD-domain reset, active low; consumers resynchronize it into the pixel clock
- ready  out  1  PLL locked and LCD domain released
- fault  out  1  sticky; retries exhausted
- retry_cnt  out  2  timeouts since last successful lock
- lock_lost  out  1  one-cycle pulse on lock drop while in RUN

## Operation
- pll_lock passes through a 2-flop synchronizer to lock_s. No other logic samples pll_lock directly.
- States:
  - PLLRST: pll_reset=1. After RESET_CYCLES cycles, go to WAIT.
  - WAIT: timeout counter cleared on entry. If lock_s=1, go to STABLE. Otherwise, on timeout (watchdog build), go to PLLRST with retry_cnt+1, or go to FAULT if retry_cnt==MAX_RETRY.
  - STABLE: stable counter cleared on entry and counts each cycle with lock_s=1. If lock_s=0, go to WAIT. On count STABLE_CYCLES-1 with lock_s=1, go to RUN and clear retry_cnt.
  - RUN: lcd_rst_n=1, ready=1. If lock_s=0, pulse lock_lost and go to PLLRST. retry_cnt is not incremented on this path.
  - FAULT: pll_reset=1, lcd_rst_n=0, fault=1. Exited only by rst_n.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state change.
- Counter widths are $clog2 of their parameter. No wrap occurs, because every counter is cleared on state entry.
- Simultaneous events:
  - In WAIT, lock_s=1 on the timeout cycle: lock wins.
  - In RUN, lock drops: lock_lost and pll_reset both rise on the same edge.
- rst_n low mid-sequence overrides everything. The next edge returns the block to PLLRST with reset values.

## Timing
- Reset values: pll_reset=1, lcd_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_lost=0, state PLLRST.
- After rst_n deasserts, pll_reset stays high for exactly RESET_CYCLES edges.
- pll_lock rising while in WAIT: ready and lcd_rst_n rise STABLE_CYCLES+3 edges later (2 synchronizer edges, 1 WAIT→STABLE edge, STABLE_CYCLES count edges).
- pll_lock falling while in RUN: ready falls, lcd_rst_n falls, and pll_reset rises 3 edges later.
- Timeout: the WAIT→PLLRST transition occurs on the LOCK_TIMEOUT-th edge after WAIT entry.

## Configuration
- LCD_PLL_WATCHDOG_EN defined:
  - The WAIT timeout, retry counting and FAULT state are compiled in.
  - LOCK_TIMEOUT and MAX_RETRY are honoured.
- LCD_PLL_WATCHDOG_EN undefined:
  - WAIT waits for lock indefinitely.
  - fault is tied to 0 and retry_cnt to 0.
  - The timeout counter and FAULT state are not synthesized.

## Test plan
Benches use STABLE_CYCLES=8, RESET_CYCLES=4, LOCK_TIMEOUT=32, MAX_RETRY=2 and the watchdog build, except scenario 6.
1. Release rst_n; raise pll_lock 10 cycles later and hold it. Required: pll_reset high for 4 edges; ready and lcd_rst_n rise 11 edges after pll_lock; retry_cnt=0.
2. Reach RUN, then drop pll_lock for 1 cycle. Required: lock_lost pulses once 3 edges later; pll_reset high for 4 edges; re-lock yields ready again after 11 edges.
3. Hold pll_lock low. Required: PLLRST→WAIT repeats twice with retry_cnt 1, then 2; the third timeout sets fault=1, pll_reset=1, lcd_rst_n=0, held until rst_n.
4. Glitch pll_lock low for 2 cycles in the middle of STABLE. Required: ready does not rise; the stable count restarts; ready rises 8 edges after lock_s re-asserts plus the WAIT→STABLE edge.
5. Pull rst_n low for 1 cycle while in RUN. Required: all outputs return to reset values on the next edge; a full sequence follows.
6. LCD_PLL_WATCHDOG_EN undefined, pll_lock low for 1000 cycles then high. Required: no retries, fault stays 0, ready rises 11 edges after lock.
